// File: rtl/add_pkg.sv
// add_pkg: sizing and saturation-constant helpers shared by the add_pipe slice.
package add_pkg;
    localparam int MAX_W = 64;

    function automatic int seg_width(input int width, input int segs);
        return width / segs;
    endfunction

    function automatic bit seg_ok(input int width, input int segs);
        return segs > 0 && width % segs == 0;
    endfunction

    function automatic logic [MAX_W-1:0] umax(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] smax(input int w);
        return umax(w) >> 1;
    endfunction

    function automatic logic [MAX_W-1:0] smin(input int w);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction
endpackage

// File: rtl/add_pipe_cla_segment.sv
// cla_segment: combinational W-bit carry look-ahead adder slice.
module cla_segment #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);
    logic [W-1:0] g, p;
    logic [W:0]   c;
    logic         t;

    function automatic logic [W-1:0] lo(input int n);
        lo = '0;
        for (int k = 0; k < n; k++) lo[k] = 1'b1;
    endfunction

    assign g = a & b;
    assign p = a ^ b;

    // every carry is a flat sum of generate terms gated by the propagates above them
    always_comb begin
        c = '0;
        t = 1'b0;
        for (int i = 0; i <= W; i++) begin
            t = ci & (&(p | ~lo(i)));
            for (int j = 0; j < i; j++) t = t | (g[j] & (&(p | ~(lo(i) & ~lo(j + 1)))));
            c[i] = t;
        end
    end

    assign s  = p ^ c[W-1:0];
    assign co = c[W];
    assign cm = c[W-1];
endmodule

// File: rtl/add_pipe.sv
// add_pipe: streaming add/sub built from SEGS pipelined carry look-ahead segments,
// with unsigned/signed overflow detection and optional saturation.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int SEGS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             signed_mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int SW = seg_width(WIDTH, SEGS);
    localparam logic [MAX_W-1:0] UMAX = umax(WIDTH);
    localparam logic [MAX_W-1:0] SMAX = smax(WIDTH);
    localparam logic [MAX_W-1:0] SMIN = smin(WIDTH);

    if (!seg_ok(WIDTH, SEGS)) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be a multiple of SEGS");
    end

    // a and b double as the skew registers, s as the de-skew register
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sub;
        logic             sgn;
        logic             sat;
    } stage_t;

    stage_t                  st_q [SEGS];
    stage_t                  st_d [SEGS];
    stage_t                  src  [SEGS];
    logic [SEGS-1:0][SW-1:0] seg_s;
    logic [SEGS-1:0]         seg_c, seg_cm;
    logic                    en, ov_d, ov_q, co_q;
    logic [WIDTH-1:0]        sum_d, sum_q;

    assign en = !st_q[SEGS-1].v || out_ready;

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        if (k == 0) begin : g_in
            assign src[k] = '{v: in_valid, a: a, b: sub ? ~b : b, s: {WIDTH{1'b0}},
                              c: sub, sub: sub, sgn: signed_mode, sat: sat};
        end else begin : g_skew
            assign src[k] = st_q[k-1];
        end
        cla_segment #(.W(SW)) u_cla (
            .a  (src[k].a[k*SW +: SW]),
            .b  (src[k].b[k*SW +: SW]),
            .ci (src[k].c),
            .s  (seg_s[k]),
            .co (seg_c[k]),
            .cm (seg_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < SEGS; k++) begin
            st_d[k] = src[k];
            st_d[k].s[k*SW +: SW] = seg_s[k];
            st_d[k].c = seg_c[k];
        end
        ov_d  = st_d[SEGS-1].sgn ? seg_cm[SEGS-1] ^ seg_c[SEGS-1] : seg_c[SEGS-1] ^ st_d[SEGS-1].sub;
        sum_d = !(st_d[SEGS-1].sat && ov_d) ? st_d[SEGS-1].s
              : st_d[SEGS-1].sgn ? (st_d[SEGS-1].a[WIDTH-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0])
              : st_d[SEGS-1].sub ? {WIDTH{1'b0}} : UMAX[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SEGS; k++) st_q[k] <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < SEGS; k++) st_q[k] <= st_d[k];
            sum_q <= sum_d;
            co_q  <= seg_c[SEGS-1];
            ov_q  <= ov_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = st_q[SEGS-1].v;
    assign sum       = sum_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and randomized checks of add_pipe against an arithmetic reference model.
module tb_add_pipe;
    localparam int W = 6;
    localparam int S = 2;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic         sub = 1'b0, signed_mode = 1'b0, sat = 1'b0, carry_out, overflow;
    logic [W-1:0] a = '0, b = '0, sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0;

    add_pipe #(.WIDTH(W), .SEGS(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .signed_mode (signed_mode),
        .sat         (sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // plain integer arithmetic: true results, then mode rules on representability
    function automatic exp_t model(input int ua, input int ub, input logic s, input logic sg, input logic st);
        exp_t e;
        int   r, sr;
        r    = s ? ua - ub : ua + ub;
        sr   = (ua > M / 2 ? ua - M - 1 : ua) + (s ? -1 : 1) * (ub > M / 2 ? ub - M - 1 : ub);
        e.co = s ? ua >= ub : r > M;
        e.ov = sg ? (sr > M / 2 || sr < -M / 2 - 1) : (s ? ua < ub : r > M);
        e.sum = W'(r & M);
        if (st && e.ov) e.sum = sg ? W'(sr > 0 ? M / 2 : M / 2 + 1) : (s ? '0 : W'(M));
        e.due = 0;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        logic vexp, stall;
        @(negedge clk);
        if (rst) q.delete();
        else begin
            vexp  = q.size() != 0 && q[0].due <= cyc;
            stall = vexp && !out_ready;
            chk("out_valid", out_valid, vexp);
            chk("in_ready", in_ready, !stall);
            if (vexp) begin
                chk("sum", sum, q[0].sum);
                chk("carry_out", carry_out, q[0].co);
                chk("overflow", overflow, q[0].ov);
                if (out_ready) void'(q.pop_front());
            end
            if (stall) foreach (q[i]) q[i].due++;
            else if (in_valid) begin
                e = model(a, b, sub, signed_mode, sat);
                e.due = cyc + S;
                q.push_back(e);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd();
        a           = W'($urandom);
        b           = W'($urandom);
        sub         = $urandom_range(0, 1) == 1;
        signed_mode = $urandom_range(0, 1) == 1;
        sat         = $urandom_range(0, 1) == 1;
    endtask

    task automatic beat(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic s, input logic sg, input logic st,
                        input logic [W-1:0] es, input logic eco, input logic eov);
        int n;
        out_ready = 1'b1;
        {a, b, sub, signed_mode, sat, in_valid} = {aa, bb, s, sg, st, 1'b1};
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, S);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_carry"}, carry_out, eco);
        chk({tag, "_ovf"}, overflow, eov);
        step();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int   sent;
        logic acc;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        beat("uadd_21_10", 6'd21, 6'd10, 1'b0, 1'b0, 1'b0, 6'd31, 1'b0, 1'b0);
        beat("uadd_63_1", 6'd63, 6'd1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
        beat("uadd_63_1_sat", 6'd63, 6'd1, 1'b0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b1);
        beat("usub_5_9", 6'd5, 6'd9, 1'b1, 1'b0, 1'b0, 6'd60, 1'b0, 1'b1);
        beat("usub_5_9_sat", 6'd5, 6'd9, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1);
        beat("sadd_31_1", 6'd31, 6'd1, 1'b0, 1'b1, 1'b0, 6'd32, 1'b0, 1'b1);
        beat("sadd_31_1_sat", 6'd31, 6'd1, 1'b0, 1'b1, 1'b1, 6'd31, 1'b0, 1'b1);
        beat("ssub_m32_1_sat", 6'd32, 6'd1, 1'b1, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1);

        sent = 0;
        rnd();
        for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = sent < 6;
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                sent++;
                rnd();
            end
        end
        chk("stream_sent", sent, 6);
        drain();

        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            acc = in_valid && in_ready;
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                rnd();
            end
            step();
        end
        drain();

        out_ready = 1'b1;
        in_valid  = 1'b1;
        rnd();
        step();
        rnd();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 0);
        chk("midrst_carry", carry_out, 1'b0);
        chk("midrst_ovf", overflow, 1'b0);
        beat("post_rst", 6'd21, 6'd10, 1'b0, 1'b0, 1'b0, 6'd31, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
